ifft_butterfly: RTL and testbench

Pipelined radix-2 decimation-in-frequency complex butterfly for the 16-point, 16-bit fixed-point (Q5.10, 1024 = 1.0) IFFT core.
- Sits directly downstream of the twiddle-factor ROM: it drives the ROM read address from (stage, k) and consumes the returned real/imaginary twiddle in the same cycle.
- Produces A = a + b and B = (a − b)·W with rounding and saturation.
- Uses a 3-stage pipeline with valid/ready flow control.

---
 rtl/ifft_butterfly.sv | 129 ++++++++++++
 tb/tb_ifft_butterfly.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_butterfly.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ifft_butterfly : pipelined radix-2 DIF complex butterfly with twiddle ROM
//                  address generation, rounding and optional saturation.
// Build option    : IFFT_BF_SAT_EN (defined = saturate, undefined = wrap)
// Revision        : 1.0
// ============================================================================
module ifft_butterfly #(
    parameter int DW   = 16,
    parameter int FRAC = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_stage,
    input  logic [2:0]           in_k,
    input  logic signed [DW-1:0] a_real,
    input  logic signed [DW-1:0] a_imag,
    input  logic signed [DW-1:0] b_real,
    input  logic signed [DW-1:0] b_imag,
    output logic [3:0]           tf_rd_add,
    input  logic signed [DW-1:0] tf_real,
    input  logic signed [DW-1:0] tf_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] A_real,
    output logic signed [DW-1:0] A_imag,
    output logic signed [DW-1:0] B_real,
    output logic signed [DW-1:0] B_imag
);
    localparam int SW = DW + 1;
    localparam int PW = SW + DW;
    localparam int BW = PW + 1;
    localparam logic signed [BW-1:0] RND = BW'(2 ** (FRAC - 1));

    logic                 en;
    logic                 v1;
    logic                 v2;
    logic signed [SW-1:0] s1_real, s1_imag, d1_real, d1_imag;
    logic signed [SW-1:0] s2_real, s2_imag;
    logic signed [DW-1:0] w1_real, w1_imag;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [BW-1:0] br_rnd, bi_rnd;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_comb begin
        tf_rd_add = 4'd0;
        case (in_stage)
            2'd0:    tf_rd_add = {1'b0, in_k};
            2'd1:    tf_rd_add = {2'b10, in_k[1:0]};
            2'd2:    tf_rd_add = {3'b110, in_k[0]};
            default: tf_rd_add = 4'd14;
        endcase
    end

    function automatic logic signed [DW-1:0] fit(input logic signed [BW-1:0] v);
`ifdef IFFT_BF_SAT_EN
        localparam logic signed [BW-1:0] MAXV = BW'(2 ** (DW - 1) - 1);
        localparam logic signed [BW-1:0] MINV = ~MAXV;
        if (v > MAXV) begin
            return DW'(MAXV);
        end else if (v < MINV) begin
            return DW'(MINV);
        end
        return DW'(v);
`else
        return DW'(v);
`endif
    endfunction

    // Round half-up, then arithmetic shift back to the sample scale
    always_comb begin
        br_rnd = (BW'(p_rr) - BW'(p_ii) + RND) >>> FRAC;
        bi_rnd = (BW'(p_ri) + BW'(p_ir) + RND) >>> FRAC;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            s1_real   <= '0;
            s1_imag   <= '0;
            d1_real   <= '0;
            d1_imag   <= '0;
            w1_real   <= '0;
            w1_imag   <= '0;
            s2_real   <= '0;
            s2_imag   <= '0;
            p_rr      <= '0;
            p_ii      <= '0;
            p_ri      <= '0;
            p_ir      <= '0;
            A_real    <= '0;
            A_imag    <= '0;
            B_real    <= '0;
            B_imag    <= '0;
        end else if (en) begin
            // en doubles as in_ready, so in_valid alone marks an accepted pair
            v1        <= in_valid;
            s1_real   <= SW'(a_real) + SW'(b_real);
            s1_imag   <= SW'(a_imag) + SW'(b_imag);
            d1_real   <= SW'(a_real) - SW'(b_real);
            d1_imag   <= SW'(a_imag) - SW'(b_imag);
            w1_real   <= tf_real;
            w1_imag   <= tf_imag;

            v2        <= v1;
            s2_real   <= s1_real;
            s2_imag   <= s1_imag;
            p_rr      <= PW'(d1_real) * PW'(w1_real);
            p_ii      <= PW'(d1_imag) * PW'(w1_imag);
            p_ri      <= PW'(d1_real) * PW'(w1_imag);
            p_ir      <= PW'(d1_imag) * PW'(w1_real);

            out_valid <= v2;
            A_real    <= fit(BW'(s2_real));
            A_imag    <= fit(BW'(s2_imag));
            B_real    <= fit(br_rnd);
            B_imag    <= fit(bi_rnd);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifft_butterfly.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ifft_butterfly : scoreboard bench for ifft_butterfly (both build options).
// Revision          : 1.0
// ============================================================================
module tb_ifft_butterfly;
    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         in_stage = '0;
    logic [2:0]         in_k = '0;
    logic signed [15:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;
    logic [3:0]         tf_rd_add;
    logic signed [15:0] tf_real, tf_imag;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] A_real, A_imag, B_real, B_imag;

    typedef struct {
        logic [63:0] data;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t               exp_q[$];
    int                 checks = 0;
    int                 failures = 0;
    int                 cyc = 0;
    bit                 lat_on = 1'b1;
    logic signed [15:0] rom_re[16];
    logic signed [15:0] rom_im[16];

    ifft_butterfly #(.DW(16), .FRAC(10)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_stage(in_stage), .in_k(in_k),
        .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
        .tf_rd_add(tf_rd_add), .tf_real(tf_real), .tf_imag(tf_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_real(A_real), .A_imag(A_imag), .B_real(B_real), .B_imag(B_imag)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign tf_real = rom_re[tf_rd_add];
    assign tf_imag = rom_im[tf_rd_add];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] fit(input longint v);
`ifdef IFFT_BF_SAT_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    function automatic logic [63:0] model(input int ar, input int ai, input int br,
                                          input int bi, input int wr, input int wi);
        longint dr, di, xr, xi;
        dr = longint'(ar) - br;
        di = longint'(ai) - bi;
        xr = (dr * wr - di * wi + 512) >>> 10;
        xi = (dr * wi + di * wr + 512) >>> 10;
        return {fit(longint'(ar) + br), fit(longint'(ai) + bi), fit(xr), fit(xi)};
    endfunction

    function automatic int addr_of(input int st, input int k);
        case (st)
            0:       return k & 7;
            1:       return 8 + (k & 3);
            2:       return 12 + (k & 1);
            default: return 14;
        endcase
    endfunction

    task automatic send(input int st, input int k, input int ar, input int ai,
                        input int br, input int bi);
        int   guard = 0;
        int   ea;
        exp_t e;
        ea       = addr_of(st, k);
        in_valid = 1'b1;
        in_stage = 2'(st);
        in_k     = 3'(k);
        a_real   = 16'(ar);
        a_imag   = 16'(ai);
        b_real   = 16'(br);
        b_imag   = 16'(bi);
        forever begin
            @(negedge CLK);
            if (in_ready) break;
            guard++;
            if (guard > 50) begin
                check("accept_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        check("tf_rd_add", 64'(tf_rd_add), 64'(ea));
        e.data = model(ar, ai, br, bi, rom_re[ea], rom_im[ea]);
        e.cyc  = cyc;
        e.lat  = lat_on;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Output side: pop on every transfer, watch stability and in_ready while stalled
    initial begin
        logic [63:0] held;
        bit          held_v;
        exp_t        e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                held_v = 1'b0;
            end else begin
                if (held_v && out_valid)
                    check("stall_stable", {A_real, A_imag, B_real, B_imag}, held);
                if (out_valid && !out_ready)
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                held_v = out_valid && !out_ready;
                held   = {A_real, A_imag, B_real, B_imag};
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_output", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {A_real, A_imag, B_real, B_imag}, e.data);
                        if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd3);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            rom_re[i] = 16'(1000 - 90 * i);
            rom_im[i] = 16'(60 * i - 400);
        end
        rom_re[1]  = 16'(946);  rom_im[1]  = 16'(392);
        rom_re[2]  = 16'(724);  rom_im[2]  = 16'(724);
        rom_re[14] = 16'(1024); rom_im[14] = 16'(0);

        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", {A_real, A_imag, B_real, B_imag}, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        send(0, 2, 1024, 0, 0, 1024);
        send(0, 1, 1, 0, 0, 0);
        send(0, 1, -1, 0, 0, 0);
        send(3, 0, 30000, -30000, 30000, -30000);
        send(1, 5, 300, -200, 100, 50);
        send(2, 7, -1500, 2500, 700, -900);
        send(3, 3, 4000, 4000, -4000, 123);
        for (int i = 0; i < 6; i++)
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                 rnd16(), rnd16(), rnd16(), rnd16());
        drain();

        lat_on = 1'b0;
        fork
            for (int i = 0; i < 8; i++)
                send(i & 3, i, rnd16(), rnd16(), rnd16(), rnd16());
            begin
                repeat (3) @(posedge CLK);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        lat_on = 1'b1;

        send(0, 3, 100, 200, 300, 400);
        send(1, 1, -100, 50, 25, -75);
        send(2, 0, 2000, -2000, 1000, 1000);
        #1;
        RST = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_outputs", {A_real, A_imag, B_real, B_imag}, 64'd0);
        check("midrst_in_flight", 64'(exp_q.size()), 64'd3);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        send(0, 5, 512, -512, -256, 256);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
